// File: rtl/obi_axil_pkg.sv
// Shared types and constants for the OBI to AXI-lite master bridge.
package obi_axil_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // Read data returned when the watchdog abandons a transaction.
  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  // Request fields captured at grant and held for the whole transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

endpackage

// File: rtl/obi_to_axil_master.sv
// OBI data port to simplified AXI-lite initiator, one transaction in flight,
// with a response watchdog that turns a hung responder into an OBI error.
module obi_to_axil_master
  import obi_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // OBI target side
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  // AXI-lite initiator side
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready
);

  // Derived from TIMEOUT_CYCLES; kept at least one bit wide when disabled.
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e            state_q, state_d;
  obi_req_t          req_q, req_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              active_c;
  logic              expire_c;
  logic              aw_hs_c;
  logic              w_hs_c;
  logic              unused_we;

  // Direction is already encoded in the FSM branch; the latched copy is kept for visibility only.
  assign unused_we = req_q.we;

  // Address and write payload come straight from the latched request so they stay stable while valid.
  assign awaddr = req_q.addr;
  assign araddr = req_q.addr;
  assign wdata  = req_q.wdata;
  assign wstrb  = req_q.be;

  // Watchdog fires on the last allowed cycle of a transaction still waiting on the responder.
  assign active_c = state_q inside {WR_ADDR, WR_RESP, RD_ADDR, RD_DATA};
  assign expire_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State, flags, counter, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic and channel handshake outputs.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    aw_hs_c       = 1'b0;
    w_hs_c        = 1'b0;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    data_err_o    = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;

    if (active_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i) begin
          req_d   = '{addr: data_addr_i, we: data_we_i, be: data_be_i, wdata: data_wdata_i};
          cnt_d   = '0;
          state_d = data_we_i ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_hs_c = awvalid && awready;
        w_hs_c  = wvalid && wready;
        if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_hs_c;
          w_done_d  = w_done_q || w_hs_c;
        end
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = rdata_q;
        data_err_o    = err_q;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A completing handshake in the expiry cycle has already moved the FSM on and wins.
    if (active_c && expire_c && (state_d == state_q)) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      rdata_d   = TIMEOUT_RDATA;
      err_d     = 1'b1;
      state_d   = RESP;
    end
  end

endmodule

// File: tb/tb_obi_to_axil_master.sv
// Bench for obi_to_axil_master: directed and random OBI traffic against a
// word-addressed reference memory, plus a short-watchdog instance.
module tb_obi_to_axil_master;

  logic clk;
  logic rst_n;

  // Main instance (default watchdog)
  logic        req, gnt, we, o_rvalid, o_err;
  logic [31:0] addr, wd, o_rdata;
  logic [3:0]  be;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  // Short-watchdog instance
  logic        s_req, s_gnt, s_we, s_rvalid_o, s_err;
  logic [31:0] s_addr, s_wd, s_rdata_o;
  logic [3:0]  s_be;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;

  int checks   = 0;
  int failures = 0;

  // Reference memory (from task arguments) and responder storage (from observed bus writes)
  logic [31:0] ref_mem [bit [29:0]];
  logic [31:0] ram     [bit [29:0]];

  obi_to_axil_master dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wd), .data_rvalid_o(o_rvalid),
    .data_rdata_o(o_rdata), .data_err_o(o_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  obi_to_axil_master #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(s_req), .data_gnt_o(s_gnt), .data_addr_i(s_addr), .data_we_i(s_we),
    .data_be_i(s_be), .data_wdata_i(s_wd), .data_rvalid_o(s_rvalid_o),
    .data_rdata_o(s_rdata_o), .data_err_o(s_err),
    .awaddr(s_awaddr), .awvalid(s_awvalid), .awready(s_awready),
    .wdata(s_wdata), .wstrb(s_wstrb), .wvalid(s_wvalid), .wready(s_wready),
    .bvalid(s_bvalid), .bready(s_bready),
    .araddr(s_araddr), .arvalid(s_arvalid), .arready(s_arready),
    .rdata(s_rdata), .rvalid(s_rvalid), .rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a, input bit from_ref);
    if (from_ref) return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    return ram.exists(a[31:2]) ? ram[a[31:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ctl"}, 32'({gnt, o_rvalid, o_err, awvalid, wvalid, bready, arvalid, rready}), 32'h0);
    chk({tag, "_rdata"}, o_rdata, 32'h0);
    chk({tag, "_awaddr"}, awaddr, 32'h0);
    chk({tag, "_araddr"}, araddr, 32'h0);
    chk({tag, "_wpay"}, wdata | 32'(wstrb), 32'h0);
  endtask

  // One OBI write; the responder readies AW/W after the given delays and sends B b_dly later.
  task automatic obi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input int aw_dly, input int w_dly, input int b_dly);
    int hs_aw, hs_w, done_c, b_hs, rv;
    int n_aw, n_w, n_b, n_rv;
    hs_aw  = 1 + aw_dly;
    hs_w   = 1 + w_dly;
    done_c = (hs_aw > hs_w) ? hs_aw : hs_w;
    b_hs   = done_c + 1 + b_dly;
    rv     = b_hs + 1;
    n_aw = 0; n_w = 0; n_b = 0; n_rv = 0;
    ref_mem[a[31:2]] = merge(rd_word(a, 1'b1), d, m);
    @(negedge clk);
    req = 1'b1; addr = a; we = 1'b1; be = m; wd = d;
    #1 chk("wr_gnt", 32'(gnt), 32'h1);
    for (int t = 1; t <= rv + 1; t++) begin
      @(negedge clk);
      req = 1'b0; addr = $urandom; wd = $urandom; be = 4'($urandom);
      awready = (t >= hs_aw) && (n_aw == 0);
      wready  = (t >= hs_w) && (n_w == 0);
      bvalid  = (n_aw > 0) && (n_w > 0) && (t >= b_hs) && (n_b == 0);
      #1;
      chk("wr_awvalid", 32'(awvalid), 32'(t <= hs_aw));
      chk("wr_wvalid", 32'(wvalid), 32'(t <= hs_w));
      chk("wr_bready", 32'(bready), 32'(t > done_c && t <= b_hs));
      chk("wr_rvalid", 32'(o_rvalid), 32'(t == rv));
      chk("wr_gnt_busy", 32'(gnt), 32'h0);
      if (awvalid) chk("wr_awaddr", awaddr, a);
      if (wvalid) begin
        chk("wr_wdata", wdata, d);
        chk("wr_wstrb", 32'(wstrb), 32'(m));
      end
      if (o_rvalid) begin
        n_rv++;
        chk("wr_err", 32'(o_err), 32'h0);
      end
      if (awvalid && awready) n_aw++;
      if (wvalid && wready) begin
        n_w++;
        ram[awaddr[31:2]] = merge(rd_word(a, 1'b0), wdata, wstrb);
      end
      if (bvalid && bready) n_b++;
    end
    chk("wr_counts", 32'({n_aw[7:0], n_w[7:0], n_b[7:0], n_rv[7:0]}), 32'h01010101);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  // One OBI read; AR accepted after ar_dly cycles, R returned r_dly cycles after that.
  task automatic obi_read(input logic [31:0] a, input int ar_dly, input int r_dly);
    int hs_ar, r_hs, rv, n_ar, n_r, n_rv;
    logic [31:0] exp_d;
    hs_ar = 1 + ar_dly;
    r_hs  = hs_ar + 1 + r_dly;
    rv    = r_hs + 1;
    n_ar = 0; n_r = 0; n_rv = 0;
    exp_d = rd_word(a, 1'b1);
    @(negedge clk);
    req = 1'b1; addr = a; we = 1'b0; be = 4'hF; wd = $urandom;
    #1 chk("rd_gnt", 32'(gnt), 32'h1);
    for (int t = 1; t <= rv + 1; t++) begin
      @(negedge clk);
      req = 1'b0; addr = $urandom; we = 1'($urandom);
      arready = (t >= hs_ar) && (n_ar == 0);
      rvalid  = (n_ar > 0) && (t >= r_hs) && (n_r == 0);
      rdata   = rvalid ? rd_word(a, 1'b0) : $urandom;
      #1;
      chk("rd_arvalid", 32'(arvalid), 32'(t <= hs_ar));
      chk("rd_rready", 32'(rready), 32'(t > hs_ar && t <= r_hs));
      chk("rd_rvalid", 32'(o_rvalid), 32'(t == rv));
      if (arvalid) chk("rd_araddr", araddr, a);
      if (o_rvalid) begin
        n_rv++;
        chk("rd_rdata", o_rdata, exp_d);
        chk("rd_err", 32'(o_err), 32'h0);
      end
      if (arvalid && arready) n_ar++;
      if (rvalid && rready) n_r++;
    end
    chk("rd_counts", 32'({n_ar[7:0], n_r[7:0], n_rv[7:0]}), 32'h010101);
    arready = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 0; addr = 0; we = 0; be = 0; wd = 0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = 0;
    s_req = 0; s_addr = 0; s_we = 0; s_be = 0; s_wd = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0;
    #1 chk_idle_zero("reset");
    chk("reset_to_ctl", 32'({s_gnt, s_rvalid_o, s_err, s_bready, s_arvalid, s_rready}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait write then read back
    obi_write(32'h0000_1000, 32'hCAFE_BABE, 4'hF, 0, 0, 0);
    obi_read(32'h0000_1000, 0, 0);
    chk("t1_value", rd_word(32'h0000_1000, 1'b1), 32'hCAFE_BABE);

    // Partial byte-enable merge
    obi_write(32'h0000_2000, 32'h1122_3344, 4'hF, 0, 0, 0);
    obi_write(32'h0000_2000, 32'h0000_AB00, 4'b0010, 0, 0, 0);
    obi_read(32'h0000_2000, 0, 0);
    chk("t2_value", rd_word(32'h0000_2000, 1'b1), 32'h1122_AB44);

    // W accepted two cycles ahead of AW
    obi_write(32'h0000_2004, 32'h5555_AAAA, 4'hF, 2, 0, 1);
    // AW ahead of W, zero strobes, unaligned address
    obi_write(32'h0000_2006, 32'hFFFF_FFFF, 4'h0, 0, 3, 0);
    obi_read(32'h0000_2004, 0, 0);

    // Slow AR and R
    obi_read(32'h0000_1000, 5, 3);

    // Random traffic over a small window so reads hit earlier writes
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = 32'h0000_3000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        obi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
      else
        obi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Watchdog on the short-timeout instance: B never arrives
    @(negedge clk);
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h0000_0040; s_wd = 32'h0BAD_F00D; s_be = 4'hF;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
    #1 chk("to_gnt", 32'(s_gnt), 32'h1);
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      s_req = 1'b0;
      #1;
      if (t == 1) begin
        chk("to_aw_w", 32'({s_awvalid, s_wvalid}), 32'h3);
        chk("to_awaddr", s_awaddr, 32'h0000_0040);
        chk("to_wpay", s_wdata ^ 32'(s_wstrb), 32'h0BAD_F00D ^ 32'hF);
      end
      chk("to_bready", 32'(s_bready), 32'(t >= 2 && t <= 8));
      chk("to_rvalid", 32'(s_rvalid_o), 32'(t == 9));
      if (t == 9) begin
        chk("to_err", 32'(s_err), 32'h1);
        chk("to_rdata", s_rdata_o, 32'hDEAD_BEEF);
      end
    end
    @(negedge clk);
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h0000_0044;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #1 chk("to_next_gnt", 32'(s_gnt), 32'h1);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      s_req = 1'b0;
      #1;
      if (t == 1) chk("to_next_ar", s_araddr ^ 32'(s_arvalid), 32'h0000_0045);
      if (t == 2) chk("to_next_rready", 32'(s_rready), 32'h1);
      chk("to_next_rvalid", 32'(s_rvalid_o), 32'(t == 3));
      if (t == 3) chk("to_next_data", {s_rdata_o[31:1], s_err}, 32'h1234_5678);
    end

    // Reset while waiting in RD_DATA
    @(negedge clk);
    req = 1'b1; addr = 32'h0000_2000; we = 1'b0;
    #1 chk("rst_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 1'b0; addr = 32'h0; arready = 1'b1;
    #1;
    @(negedge clk);
    arready = 1'b0;
    #1 chk("rst_in_rdata", 32'(rready), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_idle_zero("rst_rel");
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      #1 chk("rst_no_rvalid", 32'({o_rvalid, rready, arvalid}), 32'h0);
    end
    obi_read(32'h0000_1000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obi_to_axil_master.md
Name: obi_to_axil_master

Overview:
- Bridges the core's OBI data port (req/gnt/rvalid) to the SoC's simplified AXI-lite channels: AW/W/B without bresp, AR/R without rresp.
- Acts as the initiator that drives the on-chip RAM and peripheral responders.
- Handles one outstanding transaction at a time.
- Includes a response-timeout watchdog that reports a hung responder as an OBI error.

Parameters:
TIMEOUT_CYCLES, 256, cycles allowed from address issue to B/R handshake; 0 disables the watchdog
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived; do not override)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, asynchronous active-low reset
data_req_i  in  1  OBI request
data_gnt_o  out  1  OBI grant
data_addr_i  in  32  OBI byte address
data_we_i  in  1  1=write
data_be_i  in  4  byte enables
data_wdata_i  in  32  write data
data_rvalid_o  out  1  OBI response valid (exactly one cycle per granted request)
data_rdata_o  out  32  read data
data_err_o  out  1  error, qualified by data_rvalid_o
awaddr/awvalid  out  32/1  write address channel
awready  in  1
wdata/wstrb/wvalid  out  32/4/1  write data channel
wready  in  1
bvalid  in  1  write response
bready  out  1
araddr/arvalid  out  32/1  read address channel
arready  in  1
rdata  in  32  read data
rvalid  in  1
rready  out  1

Behaviour:
- Reset: all outputs 0; FSM=IDLE; aw_done=w_done=0; counter=0.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- data_gnt_o = data_req_i && state==IDLE (combinational).
- On grant, latch addr, we, be, wdata. Next state is WR_ADDR if we, else RD_ADDR. Counter clears.
- WR_ADDR:
  - awvalid=!aw_done and wvalid=!w_done; both rise in the same cycle, so responders that require simultaneous AW and W are served.
  - Each channel sets its done flag on its own handshake, independently.
  - Once both are done (including the same cycle), go to WR_RESP and clear the flags.
  - A valid is never dropped before its ready, except on timeout.
- WR_RESP: bready=1. On bvalid, go to RESP; rdata_q=0, err_q=0.
- RD_ADDR: arvalid=1 until arready, then RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata into rdata_q, err_q=0, go to RESP.
- RESP:
  - data_rvalid_o=1, data_rdata_o=rdata_q, data_err_o=err_q for exactly one cycle, then IDLE.
  - No grant is given in RESP, so the back-to-back request rate is one per 4 cycles minimum.
- Outputs: aw/w/ar valids, bready and rready are combinational from state and flags. awaddr/araddr/wdata/wstrb come from the latched registers and are stable while valid.
- Latency against a zero-wait responder (ready high, response next cycle):
  - grant at cycle 0
  - AW/W or AR handshake at cycle 1
  - B/R handshake at cycle 2
  - data_rvalid_o at cycle 3
- Timeout:
  - The counter increments every cycle outside IDLE/RESP.
  - When it reaches TIMEOUT_CYCLES with no completing handshake: deassert all valids and readies, err_q=1, rdata_q=32'hDEAD_BEEF, go to RESP.
  - A handshake in the same cycle as expiry wins; no error is raised.
- Unaligned addr: passed through unmodified; the responder ignores addr[1:0].
- Reset mid-transaction: immediate return to IDLE with all outputs 0. In-flight bus state is abandoned.
- data_be_i=0 write: still issued with wstrb=0 and completes normally.

Decomposition:
- obi_axil_pkg holds:
  - the state enum typedef (state_e)
  - the localparam TIMEOUT_RDATA=32'hDEAD_BEEF
  - a struct bundling the latched request fields (addr, we, be, wdata).
- No sub-module; the FSM, flags and counter are a single always_ff plus a combinational output block.

Test Plan:
1. Write 0x1000, wdata 0xCAFEBABE, be 4'hF, zero-wait RAM model -> gnt at cycle 0; awvalid=wvalid=1 with wstrb=4'hF at cycle 1; data_rvalid_o at cycle 3 with err=0. A subsequent read of 0x1000 returns 0xCAFEBABE at cycle 3.
2. Write with be 4'b0010, wdata 0x0000AB00 over an existing 0x11223344 -> read back 0x1122AB44.
3. Responder asserts wready 2 cycles before awready -> wvalid drops after its handshake while awvalid holds; exactly one B; one data_rvalid_o.
4. Read with arready held low 5 cycles and rvalid delayed 3 more -> araddr stable throughout; data_rvalid_o exactly one cycle after the R handshake.
5. TIMEOUT_CYCLES=8, responder never asserts bvalid -> 8 cycles after issue: bready drops; data_rvalid_o=1, data_err_o=1, data_rdata_o=0xDEADBEEF; the next request is granted normally.
6. rst_n pulsed low while in RD_DATA -> all outputs 0 immediately; no data_rvalid_o; IDLE after release with gnt honoured on the next req.
